mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares the single unified memory port between instruction fetch (IF) and data access (MEM stage).
- Sequences each access with an IDLE/BUSY/DONE state machine and stalls the losing requester.
- Sits between the fetch/memory stages and the multi-cycle memory; data has priority, with an optional starvation guard for fetch.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_MAX, 3, consecutive data grants tolerated while fetch waits (starvation guard only)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch requests an instruction
- if_addr  in  ADDR_W  fetch address
- flush  in  1  cancel fetch (branch redirect)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  fetch not served this cycle
- d_rd  in  1  data read request
- d_wr  in  1  data write request
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data
- d_valid  out  1  one-cycle completion pulse for data
- d_stall  out  1  data not served this cycle
- err  out  1  one-cycle pulse: d_rd and d_wr both high when sampled
- mem_en  out  1  one-cycle access start
- mem_wr  out  1  write qualifier for mem_en
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  access write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_done
- mem_done  in  1  memory completion pulse, no earlier than the cycle after mem_en

## Operation
States and transitions:
- IDLE: samples requests at the clock edge.
  - Data request (d_rd xor d_wr) wins, unless the starvation guard forces fetch.
  - Otherwise fetch wins if if_req & ~flush.
  - Grant -> BUSY; record owner; register mem_addr/mem_wdata/mem_wr.
- BUSY: mem_en is high in the first BUSY cycle only. mem_addr/mem_wr/mem_wdata are held stable for all of BUSY.
  - On mem_done: capture mem_rdata into the owner's rdata register (reads only; writes leave d_rdata unchanged), then -> DONE.
- DONE: the owner's valid pulses for this one cycle, then -> IDLE.
  - No sampling in DONE, so a request that is still high during its own completion cycle is not re-issued.

Stalls and errors:
- if_stall = if_req & ~flush & ~if_valid (combinational).
- d_stall = (d_rd | d_wr) & ~d_valid (combinational).
- d_rd & d_wr in IDLE: err pulses the next cycle; data is treated as not requesting; fetch may be granted.

Flush:
- Flush in IDLE blocks the fetch grant.
- Flush while BUSY with fetch owner sets kill. On completion, if_valid is suppressed and if_rdata is unchanged. kill clears on return to IDLE.
- Flush has no effect on data accesses.

## Timing
- Reset: state IDLE. All outputs 0: if_rdata, d_rdata, valids, err, mem_en, mem_wr, mem_addr, mem_wdata. kill and starvation counter cleared.
- Request sampled at edge N -> mem_en high in cycle N+1.
- mem_done in cycle M -> valid and rdata in cycle M+1 -> IDLE in cycle M+2.
- Minimum access = 4 cycles when mem_done arrives in the cycle after mem_en.
- mem_done outside BUSY is ignored.
- rst mid-BUSY abandons the access; no valid is produced.
- Simultaneous fetch and data request in IDLE: data granted (subject to the guard).

## Configuration
Macro: MEM_ARBITER_STARVE_EN.

Defined:
- starve_cnt (0..STARVE_MAX, saturating) increments on each data grant made while if_req & ~flush; clears on any fetch grant.
- When starve_cnt == STARVE_MAX and if_req & ~flush in IDLE, fetch is granted over data.

Undefined:
- Strict data priority; the counter and STARVE_MAX are unused.

## Structure
- Shared package/header: state encodings (ST_IDLE, ST_BUSY, ST_DONE) and owner encodings (OWN_IF, OWN_D).
- One sub-module, mem_arbiter_starve: the saturating counter plus the force_if output. It is instantiated only under MEM_ARBITER_STARVE_EN; force_if is tied 0 otherwise.

## Test plan
- Fetch only: if_req, if_addr=0x0040; mem_done 2 cycles after mem_en with mem_rdata=0x1234 -> mem_addr=0x0040, mem_wr=0, if_valid one pulse, if_rdata=0x1234, if_stall low only in that cycle.
- Collision: if_req and d_rd (d_addr=0x0100) in the same cycle -> data served first (d_valid, d_rdata from memory), then fetch granted next IDLE.
- Write: d_wr, d_addr=0x0200, d_wdata=0xBEEF -> mem_en with mem_wr=1, 0x0200, 0xBEEF; d_valid pulse; d_rdata unchanged.
- Flush during fetch BUSY -> no if_valid, if_rdata unchanged, state back to IDLE two cycles after mem_done.
- Guard, STARVE_MAX=2, macro defined: d_rd and if_req held continuously -> grant order D, D, IF, D, D, IF. Macro undefined -> D only.
- Error and reset: d_rd=d_wr=1 -> err one pulse, no mem_en. rst asserted mid-BUSY -> all outputs 0 next cycle; a later mem_done produces no valid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and access owner.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_starve.sv
// Fetch starvation guard: counts data grants made while fetch is waiting and
// raises force_if once STARVE_MAX of them have happened back to back.
module mem_arbiter_starve #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic force_if
);

  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating count of data wins over a waiting fetch; any fetch grant clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(STARVE_MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign force_if = (cnt == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one multi-cycle memory port between instruction fetch and
// data access. Data wins by default; when built with MEM_ARBITER_STARVE_EN a
// starvation guard periodically forces a waiting fetch through.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  state_t state;
  owner_t owner;
  logic   kill;

  logic d_req;
  logic if_want;
  logic grant_if;
  logic grant_d;
  logic force_if;

  // A conflicting rd+wr pair counts as no data request at all
  assign d_req    = d_rd ^ d_wr;
  assign if_want  = if_req & ~flush;
  assign grant_if = (state == ST_IDLE) & if_want & (force_if | ~d_req);
  assign grant_d  = (state == ST_IDLE) & d_req & ~grant_if;

  assign if_stall = if_req & ~flush & ~if_valid;
  assign d_stall  = (d_rd | d_wr) & ~d_valid;

`ifdef MEM_ARBITER_STARVE_EN
  mem_arbiter_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_d & if_want),
    .clr      (grant_if),
    .force_if (force_if)
  );
`else
  // Guard not built: strict data priority (expression is constant false)
  assign force_if = (STARVE_MAX < 0);
`endif

  // Access sequencer: grant in IDLE, wait for mem_done in BUSY, pulse valid in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      kill      <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en   <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          err <= d_rd & d_wr;
          if (grant_d) begin
            state     <= ST_BUSY;
            owner     <= OWN_D;
            mem_en    <= 1'b1;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_if) begin
            state     <= ST_BUSY;
            owner     <= OWN_IF;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        ST_BUSY: begin
          if (flush && (owner == OWN_IF)) begin
            kill <= 1'b1;
          end
          if (mem_done) begin
            state <= ST_DONE;
            if (owner == OWN_D) begin
              d_valid <= 1'b1;
              if (!mem_wr) begin
                d_rdata <= mem_rdata;
              end
            end else if (!(kill || flush)) begin
              // A flush landing on the completion cycle also discards the fetch
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          kill  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// single accesses against a transaction-level memory/priority model.
// Guard expectations follow MEM_ARBITER_STARVE_EN.
module tb_mem_arbiter;

  localparam int SMAX = 2;
`ifdef MEM_ARBITER_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        flush;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        err;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  int total = 0;
  int bad   = 0;
  int lat   = 2;

  logic [15:0] memarr [logic [15:0]];
  logic [15:0] resp_a;
  logic [15:0] resp_wd;
  logic        resp_w;

  mem_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .flush     (flush),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_stall   (d_stall),
    .err       (err),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (memarr.exists(a)) return memarr[a];
    return (a ^ 16'h5A5A) + 16'h0101;
  endfunction

  // Memory model: answers each mem_en with one mem_done pulse 'lat' cycles later
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        resp_a  = mem_addr;
        resp_w  = mem_wr;
        resp_wd = mem_wdata;
        repeat (lat) @(posedge clk);
        #1;
        if (resp_w) begin
          memarr[resp_a] = resp_wd;
          mem_rdata = 16'hDEAD;
        end else begin
          mem_rdata = mem_val(resp_a);
        end
        mem_done = 1'b1;
        @(posedge clk);
        #1;
        mem_done  = 1'b0;
        mem_rdata = 16'hDEAD;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b0; flush = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick(2);
    total++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {if_rdata, d_rdata, mem_addr, mem_wdata});
    end
    total++;
    if ({if_valid, d_valid, err, mem_en, mem_wr} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {if_valid, d_valid, err, mem_en, mem_wr});
    end
    total++;
    if ({if_stall, d_stall} !== 2'b00) begin
      bad++; $display("FAIL reset_stall: got %b want 00", {if_stall, d_stall});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_fetch_only;
    int n;
    bit stall_bad;
    lat = 2;
    memarr[16'h0040] = 16'h1234;
    if_req = 1'b1; if_addr = 16'h0040;
    tick(1);
    total++;
    if ({mem_en, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
      bad++; $display("FAIL fetch_issue: got en=%b wr=%b addr=%h want 1 0 0040", mem_en, mem_wr, mem_addr);
    end
    n = 0; stall_bad = (if_stall !== 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (if_valid === 1'b1) begin n = i; break; end
      if (if_stall !== 1'b1) stall_bad = 1'b1;
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL fetch_latency: got %0d want 3", n);
    end
    total++;
    if ({if_rdata, if_stall, stall_bad} !== {16'h1234, 1'b0, 1'b0}) begin
      bad++; $display("FAIL fetch_data: got rdata=%h stall=%b stall_err=%b want 1234 0 0", if_rdata, if_stall, stall_bad);
    end
    if_req = 1'b0;
    tick(1);
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_pulse: got %b want 0", if_valid);
    end
    tick(2);
  endtask

  task automatic test_collision;
    logic [15:0] exp_d;
    logic [15:0] exp_i;
    bit found;
    lat = $urandom_range(1, 3);
    exp_d = mem_val(16'h0100);
    exp_i = mem_val(16'h0080);
    if_req = 1'b1; if_addr = 16'h0080; d_rd = 1'b1; d_addr = 16'h0100;
    tick(1);
    total++;
    if ({mem_en, mem_wr, mem_addr, if_stall, d_stall} !== {1'b1, 1'b0, 16'h0100, 1'b1, 1'b1}) begin
      bad++; $display("FAIL coll_data_first: got en=%b wr=%b addr=%h stalls=%b%b want 1 0 0100 11",
                      mem_en, mem_wr, mem_addr, if_stall, d_stall);
    end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (d_valid === 1'b1) begin found = 1'b1; break; end
    end
    total++;
    if (!found || d_rdata !== exp_d) begin
      bad++; $display("FAIL coll_d_rdata: got found=%b rdata=%h want 1 %h", found, d_rdata, exp_d);
    end
    d_rd = 1'b0;
    tick(1);
    total++;
    if (mem_en !== 1'b0) begin
      bad++; $display("FAIL coll_gap: got mem_en=%b want 0", mem_en);
    end
    tick(1);
    total++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0080}) begin
      bad++; $display("FAIL coll_if_next: got en=%b addr=%h want 1 0080", mem_en, mem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (if_valid === 1'b1) begin found = 1'b1; break; end
    end
    total++;
    if (!found || if_rdata !== exp_i) begin
      bad++; $display("FAIL coll_if_rdata: got found=%b rdata=%h want 1 %h", found, if_rdata, exp_i);
    end
    if_req = 1'b0;
    tick(2);
  endtask

  task automatic test_write;
    logic [15:0] old;
    bit found;
    lat = $urandom_range(1, 3);
    old = d_rdata;
    d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    tick(1);
    total++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0200, 16'hBEEF}) begin
      bad++; $display("FAIL write_issue: got en=%b wr=%b addr=%h wdata=%h want 1 1 0200 beef",
                      mem_en, mem_wr, mem_addr, mem_wdata);
    end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (d_valid === 1'b1) begin found = 1'b1; break; end
    end
    total++;
    if (!found || d_rdata !== old) begin
      bad++; $display("FAIL write_rdata_kept: got found=%b rdata=%h want 1 %h", found, d_rdata, old);
    end
    d_wr = 1'b0;
    tick(2);
  endtask

  task automatic test_flush;
    logic [15:0] old;
    bit found;
    bit seen_v;
    int n;
    lat = 3;
    old = if_rdata;
    if_req = 1'b1; if_addr = 16'h0300;
    tick(1);
    total++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0300}) begin
      bad++; $display("FAIL flush_issue: got en=%b addr=%h want 1 0300", mem_en, mem_addr);
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0; if_req = 1'b0;
    found = 1'b0; seen_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_done === 1'b1) begin found = 1'b1; break; end
      if (if_valid === 1'b1) seen_v = 1'b1;
      tick(1);
    end
    // Data request raised in the mem_done cycle is first sampled in IDLE
    d_rd = 1'b1; d_addr = 16'h0400;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (if_valid === 1'b1) seen_v = 1'b1;
      if (mem_en === 1'b1) begin n = i; break; end
    end
    total++;
    if (!found || n != 3) begin
      bad++; $display("FAIL flush_idle_return: got done=%b cycles=%0d want 1 3", found, n);
    end
    total++;
    if (seen_v !== 1'b0 || if_rdata !== old) begin
      bad++; $display("FAIL flush_suppress: got valid_seen=%b rdata=%h want 0 %h", seen_v, if_rdata, old);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (d_valid === 1'b1) break;
    end
    d_rd = 1'b0;
    tick(2);
  endtask

  task automatic test_error;
    bit found;
    lat = 1;
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0800;
    tick(1);
    total++;
    if ({err, mem_en} !== 2'b10) begin
      bad++; $display("FAIL err_pulse: got err=%b mem_en=%b want 1 0", err, mem_en);
    end
    d_rd = 1'b0; d_wr = 1'b0;
    tick(1);
    total++;
    if ({err, mem_en} !== 2'b00) begin
      bad++; $display("FAIL err_single: got err=%b mem_en=%b want 0 0", err, mem_en);
    end
    d_rd = 1'b1; d_wr = 1'b1; if_req = 1'b1; if_addr = 16'h0900;
    tick(1);
    total++;
    if ({err, mem_en, mem_addr} !== {1'b1, 1'b1, 16'h0900}) begin
      bad++; $display("FAIL err_fetch_wins: got err=%b en=%b addr=%h want 1 1 0900", err, mem_en, mem_addr);
    end
    d_rd = 1'b0; d_wr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (if_valid === 1'b1) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL err_fetch_done: got valid=0 want 1");
    end
    if_req = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid_busy;
    bit seen;
    lat = 3;
    if_req = 1'b1; if_addr = 16'h0A00;
    tick(1);
    total++;
    if (mem_en !== 1'b1) begin
      bad++; $display("FAIL rstbusy_issue: got %b want 1", mem_en);
    end
    if_req = 1'b0; rst = 1'b1;
    tick(1);
    total++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata, if_valid, d_valid, err, mem_en, mem_wr} !== 69'h0) begin
      bad++; $display("FAIL rstbusy_zero: got %h want 0",
                      {if_rdata, d_rdata, mem_addr, mem_wdata, if_valid, d_valid, err, mem_en, mem_wr});
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (if_valid === 1'b1 || d_valid === 1'b1 || mem_en === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rstbusy_no_valid: got activity=1 want 0");
    end
  endtask

  task automatic test_starve;
    int k;
    int cycles;
    bit exp_if;
    bit got_if;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    lat = $urandom_range(1, 3);
    if_req = 1'b1; if_addr = 16'h0600; d_rd = 1'b1; d_addr = 16'h0700;
    k = 0; cycles = 0;
    while (k < 6 && cycles < 200) begin
      tick(1);
      cycles++;
      if (mem_en === 1'b1) begin
        k++;
        // With the guard every (SMAX+1)-th grant goes to fetch
        exp_if = STARVE_ON && ((k % (SMAX + 1)) == 0);
        got_if = (mem_addr === 16'h0600);
        total++;
        if (got_if !== exp_if) begin
          bad++; $display("FAIL starve_grant%0d: got fetch=%b want %b", k, got_if, exp_if);
        end
      end
    end
    total++;
    if (k != 6) begin
      bad++; $display("FAIL starve_timeout: got %0d grants want 6", k);
    end
    if_req = 1'b0; d_rd = 1'b0;
    tick(10);
  endtask

  task automatic test_random;
    int kind;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp;
    logic [15:0] got;
    bit found;
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 2);
      a = 16'($urandom);
      wd = 16'($urandom);
      lat = $urandom_range(1, 4);
      if (kind == 0) begin
        exp = mem_val(a); if_req = 1'b1; if_addr = a;
      end else if (kind == 1) begin
        exp = mem_val(a); d_rd = 1'b1; d_addr = a;
      end else begin
        exp = d_rdata; d_wr = 1'b1; d_addr = a; d_wdata = wd;
      end
      tick(1);
      total++;
      if ({mem_en, mem_wr, mem_addr} !== {1'b1, (kind == 2), a}) begin
        bad++; $display("FAIL rand%0d_issue: got en=%b wr=%b addr=%h want 1 %b %h",
                        t, mem_en, mem_wr, mem_addr, (kind == 2), a);
      end
      found = 1'b0; got = '0;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (kind == 0 && if_valid === 1'b1) begin found = 1'b1; got = if_rdata; break; end
        if (kind != 0 && d_valid === 1'b1) begin found = 1'b1; got = d_rdata; break; end
      end
      total++;
      if (!found || got !== exp) begin
        bad++; $display("FAIL rand%0d_data: got found=%b data=%h want 1 %h", t, found, got, exp);
      end
      if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      tick(2);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; flush = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_fetch_only();
    test_collision();
    test_write();
    test_flush();
    test_error();
    test_reset_mid_busy();
    test_starve();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
